// File: rtl/clock_pkg.sv
// Shared state encoding and elaboration helpers for the clock supervisor.
package clock_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear on rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/clock_supervisor.sv
// Sequences the MMCM reset, waits for a stable lock, then releases the system reset.
// Repeated lock failures latch a fault until the next rst.
module clock_supervisor
  import clock_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       clk_locked,
  output logic       mmcm_rst,
  output logic       sys_rst,
  output logic [7:0] relock_count,
  output logic       fault
);

  localparam int TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY - 1);

  logic               locked_s;
  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               armed_reg;
  logic [7:0]         relock_next;

  sync_2ff u_sync (
    .clk (clk_100m),
    .rst (rst),
    .d   (clk_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg + 1'b1;
    retry_next  = retry_reg;
    relock_next = relock_count;

    case (state_reg)
      RESET: begin
        // The first edge after rst only arms the counter, so the pulse
        // spans a full RST_CYCLES edges just as it does on a retry.
        if (!armed_reg) begin
          timer_next = timer_reg;
        end else if (timer_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
          timer_next = '0;
        end else if (timer_reg == LOCK_LAST) begin
          state_next = (retry_reg == RETRY_LAST) ? FAULT : RESET;
          retry_next = retry_reg + 1'b1;
          timer_next = '0;
        end
      end

      STABLE: begin
        if (!locked_s) begin
          state_next = (retry_reg == RETRY_LAST) ? FAULT : RESET;
          retry_next = retry_reg + 1'b1;
          timer_next = '0;
        end else if (timer_reg == STABLE_LAST) begin
          state_next = RUN;
          retry_next = '0;
          timer_next = '0;
        end
      end

      RUN: begin
        timer_next = '0;
        if (!locked_s) begin
          state_next  = RESET;
          relock_next = (relock_count == 8'hFF) ? relock_count : relock_count + 8'd1;
        end
      end

      FAULT: begin
        timer_next = '0;
      end

      default: begin
        state_next = RESET;
        timer_next = '0;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_reg    <= RESET;
      timer_reg    <= '0;
      retry_reg    <= '0;
      armed_reg    <= 1'b0;
      relock_count <= 8'd0;
      mmcm_rst     <= 1'b1;
      sys_rst      <= 1'b1;
      fault        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      retry_reg    <= retry_next;
      armed_reg    <= 1'b1;
      relock_count <= relock_next;
      mmcm_rst     <= (state_next == RESET) || (state_next == FAULT);
      sys_rst      <= (state_next != RUN);
      fault        <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_clock_supervisor.sv
// Randomised bench for clock_supervisor against an edge-count reference model,
// plus directed checks of the power-up, glitch, relock, fault and async-reset cases.
module tb_clock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 3;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       clk_100m = 1'b0;
  logic       rst = 1'b1;
  logic       clk_locked = 1'b0;
  logic       mmcm_rst;
  logic       sys_rst;
  logic       fault;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the phase plus the edge number at which it was entered.
  int m_phase;
  int m_start;
  int m_retries;
  int m_relocks;
  int edge_n;
  bit lk_hist[$];

  always #5 clk_100m = ~clk_100m;

  clock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk_100m     (clk_100m),
    .rst          (rst),
    .clk_locked   (clk_locked),
    .mmcm_rst     (mmcm_rst),
    .sys_rst      (sys_rst),
    .relock_count (relock_count),
    .fault        (fault)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_RESET;
    m_start   = 1;
    m_retries = 0;
    m_relocks = 0;
    edge_n    = 0;
    lk_hist.delete();
  endtask

  task automatic model_fail();
    m_start = edge_n;
    if (m_retries + 1 == MAX_RETRY) begin
      m_phase = P_FAULT;
    end else begin
      m_retries++;
      m_phase = P_RESET;
    end
  endtask

  // Lock status seen at edge n is the input sampled two edges earlier.
  task automatic model_edge(input bit lk);
    bit ls;
    int el;
    edge_n++;
    lk_hist.push_back(lk);
    ls = (lk_hist.size() >= 3) ? lk_hist[lk_hist.size() - 3] : 1'b0;
    if (lk_hist.size() > 3) void'(lk_hist.pop_front());
    el = edge_n - m_start;
    case (m_phase)
      P_RESET:  if (el == RST_CYCLES) begin m_phase = P_WAIT; m_start = edge_n; end
      P_WAIT: begin
        if (ls) begin m_phase = P_STABLE; m_start = edge_n; end
        else if (el == LOCK_TIMEOUT) model_fail();
      end
      P_STABLE: begin
        if (!ls) model_fail();
        else if (el == STABLE_CYCLES) begin m_phase = P_RUN; m_start = edge_n; m_retries = 0; end
      end
      P_RUN: begin
        if (!ls) begin
          m_phase = P_RESET;
          m_start = edge_n;
          if (m_relocks < 255) m_relocks++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit lk, input string tag);
    clk_locked = lk;
    @(posedge clk_100m);
    model_edge(lk);
    #1;
    check_value({tag, ".mmcm_rst"}, mmcm_rst, (m_phase == P_RESET || m_phase == P_FAULT) ? 1 : 0);
    check_value({tag, ".sys_rst"}, sys_rst, (m_phase != P_RUN) ? 1 : 0);
    check_value({tag, ".fault"}, fault, (m_phase == P_FAULT) ? 1 : 0);
    check_value({tag, ".relock"}, relock_count, m_relocks);
    @(negedge clk_100m);
  endtask

  // Called at a falling edge: asserts rst between edges and checks the outputs react at once.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_value({tag, ".rst_mmcm"}, mmcm_rst, 1);
    check_value({tag, ".rst_sys"}, sys_rst, 1);
    check_value({tag, ".rst_fault"}, fault, 0);
    check_value({tag, ".rst_relock"}, relock_count, 0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    bit lk;
    int rate;

    // Power-up with rst held across several edges.
    repeat (3) @(negedge clk_100m);
    check_value("init.mmcm_rst", mmcm_rst, 1);
    check_value("init.sys_rst", sys_rst, 1);
    check_value("init.fault", fault, 0);
    check_value("init.relock", relock_count, 0);
    model_reset();
    #4 rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(k >= 10, "pu");
      if (k == 4)  check_value("pu.mmcm_e4", mmcm_rst, 1);
      if (k == 5)  check_value("pu.mmcm_e5", mmcm_rst, 0);
      if (k == 19) check_value("pu.sys_e19", sys_rst, 1);
      if (k == 20) check_value("pu.sys_e20", sys_rst, 0);
    end
    $display("power-up: sys_rst=%0d relock=%0d", sys_rst, relock_count);

    // Three-cycle lock glitch while proving stability.
    @(negedge clk_100m);
    pulse_reset("gl");
    hi_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      step((k >= 10) && !(k >= 14 && k <= 16), "gl");
      if (k >= 10 && mmcm_rst) hi_cnt++;
      if (k == 28) check_value("gl.sys_e28", sys_rst, 1);
      if (k == 29) check_value("gl.sys_e29", sys_rst, 0);
    end
    check_value("gl.mmcm_pulse_len", hi_cnt, RST_CYCLES);
    check_value("gl.relock", relock_count, 0);
    $display("glitch: mmcm pulse %0d cycles, relock=%0d", hi_cnt, relock_count);

    // Single loss in RUN: reset visible two edges later.
    step(1'b0, "loss");
    check_value("loss.sys_m", sys_rst, 0);
    step(1'b1, "loss");
    check_value("loss.sys_m1", sys_rst, 0);
    step(1'b1, "loss");
    check_value("loss.sys_m2", sys_rst, 1);
    check_value("loss.mmcm_m2", mmcm_rst, 1);
    check_value("loss.relock1", relock_count, 1);
    for (int k = 0; k < 20; k++) step(1'b1, "loss");
    $display("loss in RUN: relock=%0d", relock_count);

    // Many losses drive the counter into saturation.
    for (int n = 0; n < 300; n++) begin
      for (int k = $urandom_range(1, 3); k > 0; k--) step(1'b0, "sat");
      for (int k = $urandom_range(18, 25); k > 0; k--) step(1'b1, "sat");
    end
    check_value("sat.relock255", relock_count, 255);
    $display("saturation: relock=%0d", relock_count);

    // Asynchronous reset from RUN clears everything before the next edge.
    pulse_reset("arst");
    $display("async reset in RUN: relock=%0d fault=%0d", relock_count, fault);

    // Never locks: fault after MAX_RETRY attempts, then lock is ignored.
    for (int k = 1; k <= 120; k++) begin
      step(1'b0, "nl");
      if (k == 108) check_value("nl.fault_e108", fault, 0);
      if (k == 109) check_value("nl.fault_e109", fault, 1);
    end
    for (int k = 0; k < 20; k++) step(1'b1, "nl");
    check_value("nl.fault_held", fault, 1);
    check_value("nl.mmcm_held", mmcm_rst, 1);
    check_value("nl.sys_held", sys_rst, 1);
    $display("never locks: fault=%0d", fault);
    pulse_reset("nlr");
    $display("async reset in FAULT: fault=%0d", fault);

    // Random lock activity at several toggle rates, with occasional resets.
    for (int r = 0; r < 5; r++) begin
      rate = 3 + r * 15;
      lk = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, rate - 1) == 0) lk = ~lk;
        step(lk, "rnd");
        if ($urandom_range(0, 299) == 0) pulse_reset("rnd");
      end
      $display("random run %0d (rate 1/%0d): relock=%0d fault=%0d", r, rate, relock_count, fault);
      pulse_reset("rndr");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_supervisor.md
CLOCK_SUPERVISOR -- requirements
Module: clock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: length in clk_100m cycles of each mmcm_rst pulse (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: number of cycles to wait for lock per attempt (1 ms at 100 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: number of cycles lock must hold before system reset releases (>=2).
REQ-004 SHALL have parameter MAX_RETRY, default 4: number of consecutive failed lock attempts before fault (>=1).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_100m  input  1  free-running board oscillator, sole clock of the block.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port clk_locked  input  1  MMCM lock status from the clock generator, asynchronous to clk_100m.
REQ-008 SHALL have port mmcm_rst  output  1  reset to the clock generator's MMCM.
REQ-009 SHALL have port sys_rst  output  1  system reset request, high until the clock is proven stable; consumers resynchronise it into their own domain.
REQ-010 SHALL have port relock_count  output  8  saturating count of lock losses that occurred in RUN.
REQ-011 SHALL have port fault  output  1  sticky flag: MAX_RETRY consecutive lock attempts failed.

Function
REQ-012 SHALL pass clk_locked through a 2-flop synchroniser to give locked_s; all decisions use locked_s only.
REQ-013 SHALL implement states RESET, WAIT_LOCK, STABLE, RUN and FAULT, with one shared timer and a retry counter.
REQ-014 In RESET, mmcm_rst SHALL be 1 for exactly RST_CYCLES cycles, then the block SHALL enter WAIT_LOCK with the timer cleared; locked_s is ignored in RESET.
REQ-015 In WAIT_LOCK, if locked_s=1 the block SHALL enter STABLE with the timer cleared.
REQ-016 In WAIT_LOCK, if the timer reaches LOCK_TIMEOUT-1 with locked_s=0, the block SHALL increment retry and enter RESET, or enter FAULT if retry+1 = MAX_RETRY.
REQ-017 In WAIT_LOCK, when locked_s=1 and the timeout occur on the same cycle, lock SHALL win.
REQ-018 In STABLE, if locked_s=0 the block SHALL count a retry (same rule as REQ-016) and enter RESET.
REQ-019 In STABLE, when the timer reaches STABLE_CYCLES-1 with locked_s=1, the block SHALL enter RUN and clear retry.
REQ-020 In RUN, locked_s=0 SHALL cause entry to RESET and relock_count increment; relock_count saturates at 255 and never wraps.
REQ-021 In FAULT, mmcm_rst=1, sys_rst=1 and fault=1 SHALL hold until rst; clk_locked is ignored.
REQ-022 All outputs SHALL be registered; sys_rst = 0 exactly while state is RUN, decoded from the next state so that it changes on the same edge as the state.
REQ-023 Latency: clk_locked rising before edge N in WAIT_LOCK SHALL give sys_rst falling at edge N+2+STABLE_CYCLES.
REQ-024 Latency: clk_locked falling before edge M in RUN SHALL give sys_rst=1 and mmcm_rst=1 at edge M+2.
REQ-025 The timer width SHALL be $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES; the retry counter width SHALL be $clog2(MAX_RETRY+1).

Reset
REQ-026 rst=1 SHALL immediately, with no clock edge: set state=RESET, mmcm_rst=1, sys_rst=1, fault=0, relock_count=0, retry=0, timer=0, clear the synchroniser flops.
REQ-027 After rst deasserts, the RESET pulse SHALL run its full RST_CYCLES count starting at the first edge.
REQ-028 rst asserted in any state, including FAULT or RUN, SHALL restart the sequence from REQ-026.

Structure
REQ-029 The state enum typedef SHALL live in shared package clock_pkg.
REQ-030 The synchroniser SHALL be sub-module sync_2ff (async reset clears both flops to 0), instantiated once.
REQ-031 No MMCM or BUFG primitives SHALL be inside this block; it pairs with the clock generator through mmcm_rst and clk_locked only.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=3)
REQ-032 Power-up: release rst before edge 1, raise clk_locked before edge 10 -> mmcm_rst=1 for edges 1-4, 0 from edge 5; sys_rst falls at edge 20; relock_count=0.
REQ-033 Glitch: from the REQ-032 stimulus, drop clk_locked for 3 cycles during STABLE -> mmcm_rst pulses 4 cycles, sys_rst stays 1 throughout, relock_count=0.
REQ-034 Loss in RUN: drop clk_locked before edge M -> sys_rst=1 and mmcm_rst=1 at M+2, relock_count=1. Then force 300 losses -> relock_count=255.
REQ-035 Never locks: hold clk_locked=0 -> fault=1 after 3 x (4+32) cycles; mmcm_rst and sys_rst stay 1; a later clk_locked=1 has no effect.
REQ-036 Async reset: assert rst mid-RUN between edges -> outputs take their REQ-026 values before the next edge; relock_count=0; fault cleared.
